// File: rtl/reg_main_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_main_multi_pkg
// Description : Shared address map, status bit positions and pulse FSM state
//               encoding for the reg_main_multi register block.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_main_multi_pkg;

   // Register address map
   localparam logic [7:0] REG_USE_PLL            = 8'h01;
   localparam logic [7:0] REG_TARGET_RESET_REG   = 8'h02;
   localparam logic [7:0] REG_TARGET_RESET_PULSE = 8'h03;
   localparam logic [7:0] REG_STATUS             = 8'h04;
   localparam logic [7:0] REG_ECHO               = 8'h05;
   localparam logic [7:0] REG_USER_BASE          = 8'h20;

   // Status register bit positions
   localparam int STATUS_BUSY_BIT    = 0;
   localparam int STATUS_PLL_BIT     = 1;
   localparam int STATUS_DROPPED_BIT = 2;

   // Pulse generator FSM encoding
   typedef enum logic [1:0] {
      PULSE_IDLE     = 2'd0,
      PULSE_ACTIVE   = 2'd1,
      PULSE_COOLDOWN = 2'd2
   } pulse_state_t;

   // Assemble the status byte from its individual flags
   function automatic logic [7:0] status_byte(input logic busy,
                                              input logic use_pll,
                                              input logic dropped);
      logic [7:0] s;
      s = 8'h00;
      s[STATUS_BUSY_BIT]    = busy;
      s[STATUS_PLL_BIT]     = use_pll;
      s[STATUS_DROPPED_BIT] = dropped;
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : reg_pulse_gen
// Description : Programmable target-reset pulse generator. A request with a
//               non-zero length produces a pulse exactly len cycles wide,
//               followed by a fixed cooldown. Requests that arrive while the
//               generator is busy are discarded and latched in 'dropped'.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_pulse_gen
   import reg_main_multi_pkg::*;
#(
   parameter int pPULSE_CNT_WIDTH = 16,
   parameter int pCOOLDOWN        = 4
) (
   input  logic                        usb_clk,
   input  logic                        reset,
   input  logic                        req,
   input  logic [pPULSE_CNT_WIDTH-1:0] len,
   input  logic                        clr_dropped,
   output logic                        pulse,
   output logic                        busy,
   output logic                        dropped
);

   localparam logic [pPULSE_CNT_WIDTH-1:0] CNT_ONE       = pPULSE_CNT_WIDTH'(1);
   localparam logic [pPULSE_CNT_WIDTH-1:0] COOLDOWN_LOAD = pPULSE_CNT_WIDTH'(pCOOLDOWN);

   pulse_state_t                  state_q, state_d;
   logic [pPULSE_CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                          dropped_q, dropped_d;

   // State, counter and drop flag registers
   always_ff @(posedge usb_clk or posedge reset) begin
      if (reset) begin
         state_q   <= PULSE_IDLE;
         cnt_q     <= '0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dropped_q <= dropped_d;
      end
   end

   // Next-state logic: the counter holds the remaining cycles of the current phase
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dropped_d = dropped_q;
      case (state_q)
         PULSE_IDLE: begin
            if (req && (len != '0)) begin
               state_d = PULSE_ACTIVE;
               cnt_d   = len;
            end
         end
         PULSE_ACTIVE: begin
            if (cnt_q == CNT_ONE) begin
               state_d = PULSE_COOLDOWN;
               cnt_d   = COOLDOWN_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         PULSE_COOLDOWN: begin
            if (cnt_q == CNT_ONE) begin
               state_d = PULSE_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = PULSE_IDLE;
            cnt_d   = '0;
         end
      endcase
      // A clear from a status read loses to a simultaneous new drop
      if (clr_dropped) begin
         dropped_d = 1'b0;
      end
      if (req && (state_q != PULSE_IDLE)) begin
         dropped_d = 1'b1;
      end
   end

   assign pulse   = (state_q == PULSE_ACTIVE);
   assign busy    = (state_q != PULSE_IDLE);
   assign dropped = dropped_q;

endmodule
`default_nettype wire

// File: rtl/reg_main_multi.sv
`default_nettype none
// ============================================================================
// Module      : reg_main_multi
// Description : usb_clk-domain register block: PLL select, level and pulsed
//               target reset, status, and a bank of multi-byte user registers
//               that commit atomically when their top byte is written.
//               Optional feature macro: REG_MAIN_MULTI_ECHO_EN (adds a
//               pREG_BYTES-wide read/write scratch register at REG_ECHO).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_main_multi
   import reg_main_multi_pkg::*;
#(
   parameter int pBYTECNT_SIZE    = 7,
   parameter int pREGISTERED_READ = 1,
   parameter int pNUM_REGS        = 4,
   parameter int pREG_BYTES       = 4,
   parameter int pPULSE_CNT_WIDTH = 16,
   parameter int pCOOLDOWN        = 4
) (
   input  logic                              usb_clk,
   input  logic                              reset,
   input  logic [7:0]                        reg_address,
   input  logic [pBYTECNT_SIZE-1:0]          reg_bytecnt,
   input  logic [7:0]                        write_data,
   input  logic                              reg_write,
   input  logic                              reg_read,
   output logic [7:0]                        read_data,
   output logic                              reg_use_pll,
   output logic                              target_reset,
   output logic                              pulse_busy,
   output logic [pNUM_REGS*pREG_BYTES*8-1:0] user_regs
);

   localparam int REG_W     = pREG_BYTES * 8;
   localparam int USER_W    = pNUM_REGS * REG_W;
   localparam int LAST_BYTE = pREG_BYTES - 1;

   // Register state
   logic              use_pll_q, use_pll_d;
   logic              tr_level_q, tr_level_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [USER_W-1:0] shadow_q, shadow_d;
   logic [USER_W-1:0] user_q, user_d;

   // Address decode
   int                user_idx;
   int                byte_idx;
   logic              user_hit;
   logic              byte_ok;
   logic              byte0;

   // Pulse generator interface
   logic                        pulse_req;
   logic [15:0]                 pulse_len_raw;
   logic [pPULSE_CNT_WIDTH-1:0] pulse_len;
   logic                        clr_dropped;
   logic                        pulse_active;
   logic                        busy;
   logic                        dropped;

   logic [7:0]        echo_byte;
   logic [7:0]        rd_d;

   // Decode the bus address into user-register index and byte-range checks
   always_comb begin
      byte_idx = int'(reg_bytecnt);
      user_idx = int'(reg_address) - int'(REG_USER_BASE);
      user_hit = (reg_address >= REG_USER_BASE) && (user_idx < pNUM_REGS);
      byte_ok  = (byte_idx < pREG_BYTES);
      byte0    = (byte_idx == 0);
   end

   // Write decode; writing the top byte of a user register commits its whole shadow
   always_comb begin
      use_pll_d  = use_pll_q;
      tr_level_d = tr_level_q;
      len_lo_d   = len_lo_q;
      shadow_d   = shadow_q;
      user_d     = user_q;
      if (reg_write) begin
         if ((reg_address == REG_USE_PLL) && byte0) begin
            use_pll_d = write_data[0];
         end
         if ((reg_address == REG_TARGET_RESET_REG) && byte0) begin
            tr_level_d = write_data[0];
         end
         if ((reg_address == REG_TARGET_RESET_PULSE) && byte0) begin
            len_lo_d = write_data;
         end
         if (user_hit && byte_ok) begin
            shadow_d[user_idx*REG_W + byte_idx*8 +: 8] = write_data;
            if (byte_idx == LAST_BYTE) begin
               user_d[user_idx*REG_W +: REG_W] = shadow_d[user_idx*REG_W +: REG_W];
            end
         end
      end
   end

   // Control and user register storage
   always_ff @(posedge usb_clk or posedge reset) begin
      if (reset) begin
         use_pll_q  <= 1'b1;
         tr_level_q <= 1'b0;
         len_lo_q   <= 8'h00;
         shadow_q   <= '0;
         user_q     <= '0;
      end else begin
         use_pll_q  <= use_pll_d;
         tr_level_q <= tr_level_d;
         len_lo_q   <= len_lo_d;
         shadow_q   <= shadow_d;
         user_q     <= user_d;
      end
   end

   // Writing the pulse MSB byte launches the request with the stored LSB byte
   always_comb begin
      pulse_req     = reg_write && (reg_address == REG_TARGET_RESET_PULSE) && (byte_idx == 1);
      pulse_len_raw = {write_data, len_lo_q};
      pulse_len     = pPULSE_CNT_WIDTH'(pulse_len_raw);
      clr_dropped   = reg_read && (reg_address == REG_STATUS) && byte0;
   end

   reg_pulse_gen #(
      .pPULSE_CNT_WIDTH (pPULSE_CNT_WIDTH),
      .pCOOLDOWN        (pCOOLDOWN)
   ) u_pulse_gen (
      .usb_clk     (usb_clk),
      .reset       (reset),
      .req         (pulse_req),
      .len         (pulse_len),
      .clr_dropped (clr_dropped),
      .pulse       (pulse_active),
      .busy        (busy),
      .dropped     (dropped)
   );

`ifdef REG_MAIN_MULTI_ECHO_EN
   logic [REG_W-1:0] echo_q, echo_d;

   // Scratch register: byte writes land directly, no commit stage
   always_comb begin
      echo_d = echo_q;
      if (reg_write && (reg_address == REG_ECHO) && byte_ok) begin
         echo_d[byte_idx*8 +: 8] = write_data;
      end
      echo_byte = byte_ok ? echo_q[byte_idx*8 +: 8] : 8'h00;
   end

   // Scratch register storage
   always_ff @(posedge usb_clk or posedge reset) begin
      if (reset) begin
         echo_q <= '0;
      end else begin
         echo_q <= echo_d;
      end
   end
`else
   assign echo_byte = 8'h00;
`endif

   // Readback mux; user registers always return the committed value
   always_comb begin
      rd_d = 8'h00;
      if (reg_read) begin
         if (user_hit) begin
            if (byte_ok) begin
               rd_d = user_q[user_idx*REG_W + byte_idx*8 +: 8];
            end
         end else begin
            case (reg_address)
               REG_USE_PLL:          if (byte0) rd_d = {7'b0, use_pll_q};
               REG_TARGET_RESET_REG: if (byte0) rd_d = {7'b0, tr_level_q};
               REG_STATUS:           if (byte0) rd_d = status_byte(busy, use_pll_q, dropped);
               REG_ECHO:             rd_d = echo_byte;
               default:              rd_d = 8'h00;
            endcase
         end
      end
   end

   generate
      if (pREGISTERED_READ != 0) begin : g_rd_reg
         logic [7:0] read_data_q;
         // Registered readback: data appears one cycle after the strobe
         always_ff @(posedge usb_clk or posedge reset) begin
            if (reset) begin
               read_data_q <= 8'h00;
            end else begin
               read_data_q <= rd_d;
            end
         end
         assign read_data = read_data_q;
      end else begin : g_rd_comb
         assign read_data = rd_d;
      end
   endgenerate

   // target_reset combines two flops, so it changes only just after a clock edge
   assign target_reset = tr_level_q | pulse_active;
   assign reg_use_pll  = use_pll_q;
   assign pulse_busy   = busy;
   assign user_regs    = user_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_main_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_main_multi
// Description : Self-checking bench for reg_main_multi with a byte-level
//               reference model of the register map and arithmetic pulse
//               timing expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_main_multi;

   localparam int NUM   = 4;
   localparam int BYTES = 4;
   localparam int BCW   = 7;
   localparam int COOL  = 4;

   logic                      usb_clk = 1'b0;
   logic                      reset;
   logic [7:0]                reg_address;
   logic [BCW-1:0]            reg_bytecnt;
   logic [7:0]                write_data;
   logic                      reg_write;
   logic                      reg_read;
   logic [7:0]                read_data;
   logic                      reg_use_pll;
   logic                      target_reset;
   logic                      pulse_busy;
   logic [NUM*BYTES*8-1:0]    user_regs;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [7:0] m_shadow [NUM][BYTES];
   logic [7:0] m_commit [NUM][BYTES];
   logic [7:0] m_echo   [BYTES];
   logic       m_pll;
   logic       m_level;

   reg_main_multi #(
      .pBYTECNT_SIZE    (BCW),
      .pREGISTERED_READ (1),
      .pNUM_REGS        (NUM),
      .pREG_BYTES       (BYTES),
      .pPULSE_CNT_WIDTH (16),
      .pCOOLDOWN        (COOL)
   ) dut (
      .usb_clk      (usb_clk),
      .reset        (reset),
      .reg_address  (reg_address),
      .reg_bytecnt  (reg_bytecnt),
      .write_data   (write_data),
      .reg_write    (reg_write),
      .reg_read     (reg_read),
      .read_data    (read_data),
      .reg_use_pll  (reg_use_pll),
      .target_reset (target_reset),
      .pulse_busy   (pulse_busy),
      .user_regs    (user_regs)
   );

   always #5 usb_clk = ~usb_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int i = 0; i < NUM; i++)
         for (int k = 0; k < BYTES; k++) begin
            m_shadow[i][k] = 8'h00;
            m_commit[i][k] = 8'h00;
         end
      for (int k = 0; k < BYTES; k++) m_echo[k] = 8'h00;
      m_pll   = 1'b1;
      m_level = 1'b0;
   endtask

   task automatic model_write(input logic [7:0] a, input int b, input logic [7:0] d);
      if (a == 8'h01 && b == 0) m_pll = d[0];
      if (a == 8'h02 && b == 0) m_level = d[0];
      if (a >= 8'h20 && int'(a) < 32 + NUM && b < BYTES) begin
         m_shadow[int'(a) - 32][b] = d;
         if (b == BYTES - 1)
            for (int k = 0; k < BYTES; k++) m_commit[int'(a) - 32][k] = m_shadow[int'(a) - 32][k];
      end
`ifdef REG_MAIN_MULTI_ECHO_EN
      if (a == 8'h05 && b < BYTES) m_echo[b] = d;
`endif
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] a, input int b);
      logic [7:0] r;
      r = 8'h00;
      if (a == 8'h01 && b == 0) r = {7'b0, m_pll};
      else if (a == 8'h02 && b == 0) r = {7'b0, m_level};
      else if (a >= 8'h20 && int'(a) < 32 + NUM && b < BYTES) r = m_commit[int'(a) - 32][b];
`ifdef REG_MAIN_MULTI_ECHO_EN
      else if (a == 8'h05 && b < BYTES) r = m_echo[b];
`endif
      return r;
   endfunction

   function automatic logic [NUM*BYTES*8-1:0] model_user_flat();
      logic [NUM*BYTES*8-1:0] r;
      for (int i = 0; i < NUM; i++)
         for (int k = 0; k < BYTES; k++) r[(i*BYTES + k)*8 +: 8] = m_commit[i][k];
      return r;
   endfunction

   task automatic tick();
      @(posedge usb_clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input int b, input logic [7:0] d);
      reg_address = a;
      reg_bytecnt = BCW'(b);
      write_data  = d;
      reg_write   = 1'b1;
      tick();
      reg_write   = 1'b0;
      model_write(a, b, d);
   endtask

   task automatic rd(input logic [7:0] a, input int b, output logic [7:0] d);
      reg_address = a;
      reg_bytecnt = BCW'(b);
      reg_read    = 1'b1;
      tick();
      d           = read_data;
      reg_read    = 1'b0;
   endtask

   task automatic test_reset();
      logic [7:0] d;
      wr(8'h21, 0, 8'h12); wr(8'h21, 1, 8'h34); wr(8'h21, 2, 8'h56); wr(8'h21, 3, 8'h78);
      wr(8'h01, 0, 8'h00);
      wr(8'h03, 0, 8'h08); wr(8'h03, 1, 8'h00);
      reg_address = 8'h21; reg_bytecnt = '0; reg_read = 1'b1;
      tick(); tick();
      n_cmp++;
      if (target_reset !== 1'b1 || read_data !== 8'h12) begin
         n_bad++;
         $display("FAIL reset_pre: target_reset=%b read_data=%h, required 1 / 12", target_reset, read_data);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if (target_reset !== 1'b0 || pulse_busy !== 1'b0 || reg_use_pll !== 1'b1 ||
          user_regs !== '0 || read_data !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_async: tr=%b busy=%b pll=%b user=%h rd=%h, required 0 0 1 0 00",
                  target_reset, pulse_busy, reg_use_pll, user_regs, read_data);
      end
      reg_read = 1'b0;
      tick(); tick();
      reset = 1'b0;
      model_reset();
      rd(8'h01, 0, d);
      n_cmp++;
      if (d !== 8'h01 || user_regs !== '0) begin
         n_bad++;
         $display("FAIL reset_readback: pll read=%h user=%h, required 01 / 0", d, user_regs);
      end
   endtask

   task automatic test_atomic();
      logic [7:0] pat [4];
      logic [7:0] d;
      pat[0] = 8'hAA; pat[1] = 8'hBB; pat[2] = 8'hCC; pat[3] = 8'hDD;
      for (int b = 0; b < 3; b++) begin
         wr(8'h20, b, pat[b]);
         n_cmp++;
         if (user_regs[31:0] !== 32'h0) begin
            n_bad++;
            $display("FAIL atomic_partial%0d: user0=%h, required 00000000", b, user_regs[31:0]);
         end
      end
      wr(8'h20, 3, pat[3]);
      n_cmp++;
      if (user_regs[31:0] !== 32'hDDCCBBAA) begin
         n_bad++;
         $display("FAIL atomic_commit: user0=%h, required ddccbbaa", user_regs[31:0]);
      end
      for (int b = 0; b < 4; b++) begin
         rd(8'h20, b, d);
         n_cmp++;
         if (d !== pat[b]) begin
            n_bad++;
            $display("FAIL atomic_read%0d: got %h, required %h", b, d, pat[b]);
         end
      end
   endtask

   task automatic test_random_regs();
      logic [7:0] a, d, e;
      int b;
      for (int it = 0; it < 40; it++) begin
         a = 8'h20 + 8'($urandom_range(0, NUM));
         b = int'($urandom_range(0, BYTES));
         d = 8'($urandom);
         wr(a, b, d);
         n_cmp++;
         if (user_regs !== model_user_flat()) begin
            n_bad++;
            $display("FAIL rand_write%0d: user=%h, required %h", it, user_regs, model_user_flat());
         end
      end
      for (int it = 0; it < 20; it++) begin
         a = 8'h20 + 8'($urandom_range(0, NUM));
         b = int'($urandom_range(0, BYTES));
         e = model_read(a, b);
         rd(a, b, d);
         n_cmp++;
         if (d !== e) begin
            n_bad++;
            $display("FAIL rand_read a=%h b=%0d: got %h, required %h", a, b, d, e);
         end
      end
   endtask

   task automatic test_pulse();
      int lens [4];
      int hi, bz;
      lens[0] = 5; lens[1] = int'($urandom_range(1, 20)); lens[2] = 258; lens[3] = 1;
      for (int t = 0; t < 4; t++) begin
         wr(8'h03, 0, 8'(lens[t])); wr(8'h03, 1, 8'(lens[t] >> 8));
         hi = 0; bz = 0;
         for (int c = 0; c < 400 && pulse_busy; c++) begin
            if (target_reset) hi++;
            bz++;
            tick();
         end
         n_cmp++;
         if (hi != lens[t] || bz != lens[t] + COOL || pulse_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_len%0d: high=%0d busy=%0d, required %0d / %0d", t, hi, bz, lens[t], lens[t] + COOL);
         end
      end
      wr(8'h03, 0, 8'h00); wr(8'h03, 1, 8'h00);
      hi = 0;
      for (int c = 0; c < 10; c++) begin
         if (target_reset || pulse_busy) hi++;
         tick();
      end
      n_cmp++;
      if (hi != 0) begin
         n_bad++;
         $display("FAIL pulse_zero: active cycles=%0d, required 0", hi);
      end
   endtask

   task automatic test_drop();
      logic [7:0] s1, s2, d;
      int hi, bz;
      wr(8'h01, 0, 8'h00);
      wr(8'h03, 0, 8'd10); wr(8'h03, 1, 8'h00);
      hi = 0; bz = 0; s1 = 8'hFF; s2 = 8'hFF;
      for (int c = 0; c < 100; c++) begin
         if (c == 11) s1 = read_data;
         if (c == 12) s2 = read_data;
         if (!pulse_busy) break;
         if (target_reset) hi++;
         bz++;
         reg_write = 1'b0; reg_read = 1'b0;
         if (c == 2) begin reg_address = 8'h03; reg_bytecnt = '0; write_data = 8'd3; reg_write = 1'b1; end
         if (c == 3) begin reg_address = 8'h03; reg_bytecnt = BCW'(1); write_data = 8'h00; reg_write = 1'b1; end
         if (c == 10 || c == 11) begin reg_address = 8'h04; reg_bytecnt = '0; reg_read = 1'b1; end
         tick();
      end
      reg_write = 1'b0; reg_read = 1'b0;
      n_cmp++;
      if (hi != 10 || bz != 10 + COOL) begin
         n_bad++;
         $display("FAIL drop_width: high=%0d busy=%0d, required 10 / %0d", hi, bz, 10 + COOL);
      end
      n_cmp++;
      if (s1 !== 8'h05 || s2 !== 8'h01) begin
         n_bad++;
         $display("FAIL drop_status: first=%h second=%h, required 05 / 01", s1, s2);
      end
      rd(8'h04, 0, d);
      tick(); tick();
      n_cmp++;
      if (d !== 8'h00 || pulse_busy !== 1'b0 || target_reset !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_idle: status=%h busy=%b tr=%b, required 00 0 0", d, pulse_busy, target_reset);
      end
      wr(8'h01, 0, 8'h01);
   endtask

   task automatic test_overlap();
      logic [7:0] d;
      wr(8'h03, 0, 8'd6); wr(8'h03, 1, 8'h00);
      tick();
      wr(8'h02, 0, 8'h01);
      rd(8'h02, 0, d);
      for (int c = 0; c < 50 && pulse_busy; c++) tick();
      n_cmp++;
      if (d !== 8'h01 || target_reset !== 1'b1 || pulse_busy !== 1'b0) begin
         n_bad++;
         $display("FAIL overlap_hold: level read=%h tr=%b busy=%b, required 01 1 0", d, target_reset, pulse_busy);
      end
      wr(8'h02, 0, 8'h00);
      n_cmp++;
      if (target_reset !== 1'b0) begin
         n_bad++;
         $display("FAIL overlap_clear: tr=%b, required 0", target_reset);
      end
   endtask

   task automatic test_edge();
      logic [7:0] d, e;
      wr(8'h21, 4, 8'h77);
      n_cmp++;
      if (user_regs !== model_user_flat()) begin
         n_bad++;
         $display("FAIL edge_bytecnt_write: user=%h, required %h", user_regs, model_user_flat());
      end
      rd(8'h21, 4, d);
      n_cmp++;
      if (d !== 8'h00) begin n_bad++; $display("FAIL edge_bytecnt_read: got %h, required 00", d); end
      rd(8'h7F, 0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_bad++; $display("FAIL edge_unmapped: got %h, required 00", d); end
      rd(8'h03, 0, d);
      n_cmp++;
      if (d !== 8'h00) begin n_bad++; $display("FAIL edge_pulse_wo: got %h, required 00", d); end
      wr(8'h05, 0, 8'h5A);
`ifdef REG_MAIN_MULTI_ECHO_EN
      e = 8'h5A;
`else
      e = 8'h00;
`endif
      rd(8'h05, 0, d);
      n_cmp++;
      if (d !== e) begin n_bad++; $display("FAIL edge_echo: got %h, required %h", d, e); end
      rd(8'h01, 0, d);
      tick();
      n_cmp++;
      if (d !== 8'h01 || read_data !== 8'h00) begin
         n_bad++;
         $display("FAIL edge_read_idle: strobed=%h idle=%h, required 01 / 00", d, read_data);
      end
   endtask

   initial begin
      reset = 1'b1; reg_address = '0; reg_bytecnt = '0; write_data = '0;
      reg_write = 1'b0; reg_read = 1'b0;
      model_reset();
      tick(); tick();
      reset = 1'b0;
      tick();
      test_reset();
      test_atomic();
      test_random_regs();
      test_pulse();
      test_drop();
      test_overlap();
      test_edge();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
